text_banner: RTL
================

# text_banner

Parametrised on-screen text banner for the VGA racing game. It generalises the fixed-position single-message overlay in four ways: selectable message, configurable position and scale, frame-timed typewriter reveal, and blink. It sits beside the other pixel generators and drives the shared 8x16 font ROM address. Its `text_on` feeds the RGB mux.

## Interface
Parameters:
- `MSG_LEN`, 8: characters per message.
- `NUM_MSG`, 4: number of messages in the message ROM.
- `X0`, 128: left edge of the banner, in pixels.
- `Y0`, 128: top edge of the banner, in pixels.
- `SCALE_LOG2`, 3: glyph magnification of 2^S. The cell is (8<<S) x (16<<S) pixels.
- `REVEAL_FRAMES`, 4: frames per newly revealed character.
- `BLINK_FRAMES`, 30: frames per blink half-period.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: banner request, level-sensitive.
- `msg_sel`, in, $clog2(NUM_MSG): message index. Sampled on the rising edge of `enable` only.
- `reveal_en`, in, 1: typewriter reveal on/off. Sampled with `msg_sel`.
- `blink_en`, in, 1: blink on/off. Live input.
- `frame_tick`, in, 1: one-cycle pulse once per frame, at the start of vblank.
- `pix_x`, in, 10: current pixel column.
- `pix_y`, in, 10: current pixel row.
- `text_on`, out, 1: current pixel lies in a visible character cell.
- `bit_addr`, out, 3: glyph column for the font ROM bit select.
- `rom_addr`, out, 11: font ROM address, {char[6:0], row[3:0]}.
- `done`, out, 1: high while the full message is shown (state SHOW).

## Operation
- FSM states: IDLE, REVEAL, SHOW.
- IDLE to REVEAL or SHOW on the `enable` rising edge, detected with a registered copy of `enable`.
  - On that edge, latch `msg_sel` and `reveal_en`.
  - If `reveal_en` is 1: go to REVEAL with `vis_cnt`=1.
  - If `reveal_en` is 0: go to SHOW with `vis_cnt`=MSG_LEN.
- REVEAL: a frame counter counts `frame_tick` pulses.
  - Every REVEAL_FRAMES ticks, `vis_cnt` increments by 1.
  - When `vis_cnt` reaches MSG_LEN, go to SHOW.
- SHOW: the blink counter counts `frame_tick` pulses.
  - Every BLINK_FRAMES ticks, `blink_ph` toggles.
  - `blink_ph` is cleared on entry to SHOW.
  - The blink counter is held at 0 outside SHOW.
- Any state to IDLE the cycle `enable` is sampled low. Counters clear.
- Changes to `msg_sel` while enabled are ignored until the next rising edge of `enable`.
- Geometry, computed in 11-bit unsigned arithmetic:
  - dx = pix_x − X0, dy = pix_y − Y0.
  - in_box = pix_x ≥ X0, pix_x < X0 + (MSG_LEN<<(3+S)), pix_y ≥ Y0, pix_y < Y0 + (16<<S).
  - col = dx>>(3+S).
  - bit = (dx>>S)[2:0].
  - row = (dy>>S)[3:0].
- Visibility: text_on = in_box ∧ state≠IDLE ∧ col < vis_cnt ∧ ¬(blink_en ∧ state==SHOW ∧ blink_ph).
- Character codes come from the message ROM at index msg*MSG_LEN+col. Space (0x20) is drawn as a normal cell.
- Parameter legality:
  - The banner box must end at or before 1024 in both axes.
  - REVEAL_FRAMES ≥ 1 and BLINK_FRAMES ≥ 1.
  - Illegal values are an elaboration error.

## Timing
- Outputs are registered. There is one cycle of latency from `pix_x`/`pix_y` to `text_on`, `bit_addr` and `rom_addr`, all three aligned.
  - The consumer delays its own pixel pipeline by 1 plus the ROM latency.
- Reset values: `text_on`=0, `bit_addr`=0, `rom_addr`=0, `done`=0, state=IDLE, all counters=0, `blink_ph`=0.
- Reset mid-operation: outputs go to their reset values asynchronously. After release, a new rising edge of `enable` is required; if `enable` is already high at release, it is not treated as an edge.
- `enable` rising and `frame_tick` in the same cycle: the start wins and the tick is not counted.
- `enable` low and `frame_tick` in the same cycle: go to IDLE and the tick is dropped.
- The final reveal tick sets `vis_cnt`=MSG_LEN and moves the FSM to SHOW in the same cycle. `done` rises on the next clock.
- Outside the box, `rom_addr` and `bit_addr` hold the last computed value. Only `text_on` is guaranteed to be 0.

## Structure
- Package `banner_pkg`:
  - font geometry constants: GLYPH_W=8, GLYPH_H=16.
  - FSM state enum.
  - message ROM contents as a constant array of 7-bit codes. Defaults, indices 0–3: "Finish  ", "GameOver", "Ready?  ", "  GO!   ".
- Sub-module `banner_msg_rom`: a combinational lookup of (msg, col) to a 7-bit code, indexed from the package array.
- The FSM, counters, geometry and output register live in `text_banner`.

## Test plan
- Defaults, `reveal_en`=0, `msg_sel`=0, raise `enable`, pixel (130,130) -> next cycle `text_on`=1, `rom_addr`={7'h46,4'h0}, `bit_addr`=0, `done`=1.
- Pixel (200,255) -> `rom_addr`={7'h69,4'hF}, `bit_addr`=1. Pixel (127,130) or (130,256) -> `text_on`=0.
- `reveal_en`=1, REVEAL_FRAMES=4 -> col 1 hidden until the 4th `frame_tick`. `done` rises 1 clock after the 28th tick. Pixel at col 7 (x=576) becomes visible only then.
- Show message 0 with `blink_en`=1 -> `text_on` at (130,130) is 0 after 30 ticks in SHOW and 1 again after 60. Change `msg_sel` to 1 mid-show -> `rom_addr` still shows 0x46.
- Drop `enable` -> `text_on`=0 and `done`=0 on the next cycle. Re-raise with `msg_sel`=1 -> (130,130) gives `rom_addr`={7'h47,4'h0} ('G').
- Assert `rst_n`=0 in REVEAL -> outputs 0 immediately. Release with `enable` held high -> stays IDLE until `enable` toggles.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared font geometry, FSM state encoding and message ROM contents for the text banner.
package banner_pkg;

    localparam int unsigned GLYPH_W       = 8;
    localparam int unsigned GLYPH_H       = 16;
    localparam int unsigned CHAR_W        = 7;
    localparam int unsigned MSG_ROM_DEPTH = 32;
    localparam int unsigned MSG_ROM_AW    = $clog2(MSG_ROM_DEPTH);
    localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_SHOW   = 2'd2
    } banner_state_t;

    // Four 8-character messages: "Finish  ", "GameOver", "Ready?  ", "  GO!   "
    localparam logic [CHAR_W-1:0] MSG_ROM [MSG_ROM_DEPTH] = '{
        7'h46, 7'h69, 7'h6E, 7'h69, 7'h73, 7'h68, 7'h20, 7'h20,
        7'h47, 7'h61, 7'h6D, 7'h65, 7'h4F, 7'h76, 7'h65, 7'h72,
        7'h52, 7'h65, 7'h61, 7'h64, 7'h79, 7'h3F, 7'h20, 7'h20,
        7'h20, 7'h20, 7'h47, 7'h4F, 7'h21, 7'h20, 7'h20, 7'h20
    };

endpackage

// File: rtl/banner_msg_rom.sv
// Combinational (message, column) to character-code lookup; out-of-table entries read as space.
module banner_msg_rom
    import banner_pkg::*;
#(
    parameter int unsigned MSG_LEN = 8,
    parameter int unsigned NUM_MSG = 4,
    parameter int unsigned COL_W   = 3
) (
    input  logic [$clog2(NUM_MSG)-1:0] msg,
    input  logic [COL_W-1:0]           col,
    output logic [CHAR_W-1:0]          code_c
);

    int unsigned idx;

    always_comb begin
        idx    = 32'(msg) * MSG_LEN + 32'(col);
        code_c = CHAR_SPACE;
        if (idx < MSG_ROM_DEPTH) begin
            code_c = MSG_ROM[idx[MSG_ROM_AW-1:0]];
        end
    end

endmodule

// File: rtl/text_banner.sv
// On-screen text banner: message select, position/scale, typewriter reveal and blink,
// driving the shared 8x16 font ROM address with one cycle of pixel latency.
module text_banner
    import banner_pkg::*;
#(
    parameter int unsigned MSG_LEN       = 8,
    parameter int unsigned NUM_MSG       = 4,
    parameter int unsigned X0            = 128,
    parameter int unsigned Y0            = 128,
    parameter int unsigned SCALE_LOG2    = 3,
    parameter int unsigned REVEAL_FRAMES = 4,
    parameter int unsigned BLINK_FRAMES  = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    input  logic                       reveal_en,
    input  logic                       blink_en,
    input  logic                       frame_tick,
    input  logic [9:0]                 pix_x,
    input  logic [9:0]                 pix_y,
    output logic                       text_on,
    output logic [2:0]                 bit_addr,
    output logic [10:0]                rom_addr,
    output logic                       done
);

    localparam int unsigned MSG_W     = $clog2(NUM_MSG);
    localparam int unsigned COL_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned VIS_W     = $clog2(MSG_LEN + 1);
    localparam int unsigned RF_W      = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam int unsigned BF_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned COL_SHIFT = $clog2(GLYPH_W) + SCALE_LOG2;
    localparam int unsigned X_END     = X0 + ((MSG_LEN * GLYPH_W) << SCALE_LOG2);
    localparam int unsigned Y_END     = Y0 + (GLYPH_H << SCALE_LOG2);

    if (X_END > 1024 || Y_END > 1024) begin : g_bad_box
        $error("text_banner: banner box extends past 1024 pixels");
    end
    if (REVEAL_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_frames
        $error("text_banner: REVEAL_FRAMES and BLINK_FRAMES must be at least 1");
    end
    if (MSG_LEN < 1 || NUM_MSG < 2) begin : g_bad_msg
        $error("text_banner: MSG_LEN must be >= 1 and NUM_MSG >= 2");
    end

    banner_state_t    state, state_n;
    logic             enable_q;
    logic [MSG_W-1:0] msg_q, msg_n;
    logic [VIS_W-1:0] vis_cnt, vis_n;
    logic [RF_W-1:0]  frame_cnt, frame_n;
    logic [BF_W-1:0]  blink_cnt, blink_cnt_n;
    logic             blink_ph, blink_ph_n;

    logic             in_box_c;
    logic [10:0]      col_c;
    logic [2:0]       bit_c;
    logic [3:0]       row_c;
    logic [CHAR_W-1:0] rom_code_c;
    logic             text_on_n;

    // 11-bit geometry; wrap on pixels left/above the box is harmless since in_box gates it
    assign in_box_c = ({1'b0, pix_x} >= 11'(X0)) && ({1'b0, pix_x} < 11'(X_END)) &&
                      ({1'b0, pix_y} >= 11'(Y0)) && ({1'b0, pix_y} < 11'(Y_END));
    assign col_c    = 11'(({1'b0, pix_x} - 11'(X0)) >> COL_SHIFT);
    assign bit_c    = 3'(({1'b0, pix_x} - 11'(X0)) >> SCALE_LOG2);
    assign row_c    = 4'(({1'b0, pix_y} - 11'(Y0)) >> SCALE_LOG2);

    banner_msg_rom #(
        .MSG_LEN (MSG_LEN),
        .NUM_MSG (NUM_MSG),
        .COL_W   (COL_W)
    ) u_msg_rom (
        .msg    (msg_n),
        .col    (COL_W'(col_c)),
        .code_c (rom_code_c)
    );

    // Next-state, counters and next output values; outputs follow the next state
    always_comb begin
        state_n     = state;
        msg_n       = msg_q;
        vis_n       = vis_cnt;
        frame_n     = frame_cnt;
        blink_cnt_n = blink_cnt;
        blink_ph_n  = blink_ph;

        if (!enable) begin
            state_n     = ST_IDLE;
            vis_n       = '0;
            frame_n     = '0;
            blink_cnt_n = '0;
            blink_ph_n  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!enable_q) begin
                        msg_n       = msg_sel;
                        frame_n     = '0;
                        blink_cnt_n = '0;
                        blink_ph_n  = 1'b0;
                        if (reveal_en && (MSG_LEN > 1)) begin
                            state_n = ST_REVEAL;
                            vis_n   = VIS_W'(1);
                        end else begin
                            state_n = ST_SHOW;
                            vis_n   = VIS_W'(MSG_LEN);
                        end
                    end
                end
                ST_REVEAL: begin
                    if (frame_tick) begin
                        if (frame_cnt == RF_W'(REVEAL_FRAMES - 1)) begin
                            frame_n = '0;
                            vis_n   = vis_cnt + VIS_W'(1);
                            if (vis_n == VIS_W'(MSG_LEN)) begin
                                state_n     = ST_SHOW;
                                blink_cnt_n = '0;
                                blink_ph_n  = 1'b0;
                            end
                        end else begin
                            frame_n = frame_cnt + RF_W'(1);
                        end
                    end
                end
                ST_SHOW: begin
                    if (frame_tick) begin
                        if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
                            blink_cnt_n = '0;
                            blink_ph_n  = ~blink_ph;
                        end else begin
                            blink_cnt_n = blink_cnt + BF_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        text_on_n = in_box_c && (state_n != ST_IDLE) && (col_c < 11'(vis_n)) &&
                    !(blink_en && (state_n == ST_SHOW) && blink_ph_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            enable_q  <= 1'b1;   // an enable already high at release is not an edge
            msg_q     <= '0;
            vis_cnt   <= '0;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            text_on   <= 1'b0;
            bit_addr  <= '0;
            rom_addr  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            enable_q  <= enable;
            msg_q     <= msg_n;
            vis_cnt   <= vis_n;
            frame_cnt <= frame_n;
            blink_cnt <= blink_cnt_n;
            blink_ph  <= blink_ph_n;
            text_on   <= text_on_n;
            done      <= (state_n == ST_SHOW);
            if (in_box_c) begin
                bit_addr <= bit_c;
                rom_addr <= {rom_code_c, row_c};
            end
        end
    end

endmodule
